morningjava_seg7_mux: RTL and testbench

Parametrised, time-multiplexed driver for a DIGITS-wide common-cathode 7-segment display.
- Accepts a packed hex word plus decimal points through a load strobe and double-buffers them.
- Scans the digits at a fixed slot rate, with an inter-digit blanking gap to suppress ghosting and optional leading-zero suppression.
- Replaces per-digit static decoders; drives the board's shared segment bus and digit-enable lines directly.

---
 rtl/morningjava_seg7_pkg.sv | 55 +++++
 rtl/morningjava_seg7_if.sv | 25 ++
 rtl/morningjava_seg7_scan.sv | 49 ++++
 rtl/morningjava_seg7_mux.sv | 141 ++++++++++++++
 tb/tb_morningjava_seg7_mux.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/morningjava_seg7_pkg.sv
// rtl/morningjava_seg7_pkg.sv - shared constants and hex decoder for the 7-segment mux
// Contents: segment bit indices (SEG_A..SEG_P), SEG_0..SEG_F patterns
// (bit order p g f e d c b a, 1 = lit), hex_to_seg() returning g..a.
package morningjava_seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F_IDX = 5;
    localparam int SEG_G = 6;
    localparam int SEG_P = 7;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_A_HEX = 8'h77;
    localparam logic [7:0] SEG_B_HEX = 8'h7C;
    localparam logic [7:0] SEG_C_HEX = 8'h39;
    localparam logic [7:0] SEG_D_HEX = 8'h5E;
    localparam logic [7:0] SEG_E_HEX = 8'h79;
    localparam logic [7:0] SEG_F_HEX = 8'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] s;
        case (hex)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A_HEX;
            4'hB:    s = SEG_B_HEX;
            4'hC:    s = SEG_C_HEX;
            4'hD:    s = SEG_D_HEX;
            4'hE:    s = SEG_E_HEX;
            default: s = SEG_F_HEX;
        endcase
        return s[6:0];
    endfunction

endpackage

// File: rtl/morningjava_seg7_if.sv
// rtl/morningjava_seg7_if.sv - host/display bundle for the 7-segment mux
// master: drives load, data_in, dp_in, lzs; observes segments, digit_en,
// frame_start, pending. slave: the display driver side.
interface morningjava_seg7_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  lzs;
    logic [7:0]            segments;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_start;
    logic                  pending;

    modport master (
        output load, data_in, dp_in, lzs,
        input  segments, digit_en, frame_start, pending
    );

    modport slave (
        input  load, data_in, dp_in, lzs,
        output segments, digit_en, frame_start, pending
    );
endinterface

// File: rtl/morningjava_seg7_scan.sv
// rtl/morningjava_seg7_scan.sv - slot counter and digit index for the scan
// Ports: clk, rst (sync active-high); idx_o current digit; blank_o high in
// the first BLANK_CYCLES of a slot; first_o at cnt==0,idx==0; boundary_o on
// the last cycle of the frame.
module morningjava_seg7_scan #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx_o,
    output logic          blank_o,
    output logic          first_o,
    output logic          boundary_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_end;
    logic          last_digit;

    always_comb begin
        slot_end   = (cnt_q == CW'(CLK_DIV - 1));
        last_digit = (idx_q == IW'(DIGITS - 1));
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o      = idx_q;
    assign blank_o    = (cnt_q < CW'(BLANK_CYCLES));
    assign first_o    = (cnt_q == '0) && (idx_q == '0);
    assign boundary_o = slot_end && last_digit;
endmodule

// File: rtl/morningjava_seg7_mux.sv
// rtl/morningjava_seg7_mux.sv - time-multiplexed common-cathode 7-segment driver
// Ports: clk, rst (sync active-high), bus (slave modport: load, data_in,
// dp_in, lzs in; segments, digit_en, frame_start, pending out).
// Optional macro MORNINGJAVA_SEG7_BRIGHTNESS_EN adds input brightness[3:0]
// and a free-running PWM that gates the lit part of each slot.
module morningjava_seg7_mux
    import morningjava_seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MORNINGJAVA_SEG7_BRIGHTNESS_EN
    input  logic [3:0]         brightness,
`endif
    morningjava_seg7_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IW-1:0]       idx;
    logic                blank, first, boundary;

    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                pending_q, pending_d;
    logic [7:0]          segments_q, segments_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                frame_start_q, frame_start_d;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          nib;
    logic                lit;

    morningjava_seg7_scan #(
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IW           (IW)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .idx_o      (idx),
        .blank_o    (blank),
        .first_o    (first),
        .boundary_o (boundary)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (DIGITS >= 1 && DIGITS <= 8 && BLANK_CYCLES >= 1 &&
                    CLK_DIV >= BLANK_CYCLES + 2)
                else $error("morningjava_seg7_mux: illegal parameter set");
        end
    end

    // Shadow/display double buffer. The display copy uses the pre-edge shadow,
    // so a load landing on the boundary stays pending for one more frame.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        pending_d     = pending_q;
        if (boundary && pending_q) begin
            disp_data_d = shadow_data_q;
            disp_dp_d   = shadow_dp_q;
            pending_d   = 1'b0;
        end
        if (bus.load) begin
            shadow_data_d = bus.data_in;
            shadow_dp_d   = bus.dp_in;
            pending_d     = 1'b1;
        end
    end

    // supp[k]: every nibble from the top digit down to k is zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        supp     = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (disp_data_q[4*k +: 4] == 4'h0);
            supp[k]  = zero_run;
        end
    end

`ifdef MORNINGJAVA_SEG7_BRIGHTNESS_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + 4'd1;
    end

    assign lit = ~blank & ((brightness == 4'hF) | (pwm_q < brightness));
`else
    assign lit = ~blank;
`endif

    always_comb begin
        nib           = disp_data_q[{idx, 2'b00} +: 4];
        segments_d    = '0;
        digit_en_d    = '0;
        frame_start_d = first;
        if (lit) begin
            digit_en_d             = DIGITS'(1) << idx;
            segments_d[SEG_P]      = disp_dp_q[idx];
            segments_d[SEG_G:SEG_A] = (bus.lzs && supp[idx]) ? 7'h00 : hex_to_seg(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            segments_q    <= '0;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            segments_q    <= segments_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.segments    = segments_q;
    assign bus.digit_en    = digit_en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_morningjava_seg7_mux.sv
// tb/tb_morningjava_seg7_mux.sv - scoreboard bench for morningjava_seg7_mux (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2)
module tb_morningjava_seg7_mux;

    logic clk = 1'b0;
    logic rst;
`ifdef MORNINGJAVA_SEG7_BRIGHTNESS_EN
    logic [3:0] brightness = 4'hF;
`endif

    always #5 clk = ~clk;

    morningjava_seg7_if #(.DIGITS(4)) bus ();

    morningjava_seg7_mux #(
        .DIGITS       (4),
        .CLK_DIV      (8),
        .BLANK_CYCLES (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MORNINGJAVA_SEG7_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .bus        (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [3:0] en;
        logic       fs;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Output at cycle c reflects the scan position one cycle earlier.
    task automatic push_at(input int c_, input logic [15:0] disp, input logic [3:0] dp,
                           input logic lz, input logic pend);
        exp_t e;
        int t, c, d;
        logic [3:0] nib;
        logic sup;
        t = c_ - 1;
        c = t % 8;
        d = (t / 8) % 4;
        e.cyc  = c_;
        e.pend = pend;
        e.fs   = (t % 32 == 0);
        if (c < 2) begin
            e.seg = 8'h00;
            e.en  = 4'b0000;
        end else begin
            e.en  = 4'b0001 << d;
            nib   = disp[4*d +: 4];
            sup   = lz && (d >= 1) && ((disp >> (4*d)) == 16'h0000);
            e.seg = {dp[d], sup ? 7'h00 : tab[nib]};
        end
        sb.push_back(e);
    endtask

    task automatic push_frame(input int f, input logic [15:0] disp, input logic [3:0] dp,
                              input logic lz, input logic pend);
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < 6; c++)
                push_at(32*f + 8*d + c + 1, disp, dp, lz, pend);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.cyc == cyc) else begin
                errors++;
                $error("FAIL sched observed=%0d expected=%0d", cyc, e.cyc);
            end
            chk("segments", bus.segments, e.seg);
            chk("digit_en", {4'b0, bus.digit_en}, {4'b0, e.en});
            chk("frame_start", {7'b0, bus.frame_start}, {7'b0, e.fs});
            chk("pending", {7'b0, bus.pending}, {7'b0, e.pend});
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bus.data_in = d;
        bus.dp_in   = p;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cyc = 0;
        bus.load = 1'b0;
        bus.data_in = '0;
        bus.dp_in = '0;
        bus.lzs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_segments", bus.segments, 8'h00);
        chk("rst_digit_en", {4'b0, bus.digit_en}, 8'h00);
        chk("rst_frame_start", {7'b0, bus.frame_start}, 8'h00);
        chk("rst_pending", {7'b0, bus.pending}, 8'h00);
        rst = 1'b0;
        cyc = 0;

        push_frame(0, 16'h0000, 4'b0000, 1'b0, 1'b0);
        push_at(31, 16'h0000, 4'b0000, 1'b0, 1'b1);
        push_frame(1, 16'h12AF, 4'b0000, 1'b0, 1'b0);
        push_at(63, 16'h12AF, 4'b0000, 1'b0, 1'b1);
        push_frame(2, 16'h0050, 4'b0100, 1'b1, 1'b0);
        push_frame(3, 16'h0050, 4'b0100, 1'b0, 1'b0);
        push_at(127, 16'h0050, 4'b0100, 1'b0, 1'b1);
        push_at(128, 16'h0050, 4'b0100, 1'b0, 1'b1);
        push_frame(4, 16'h1111, 4'b0000, 1'b0, 1'b1);
        push_frame(5, 16'h2222, 4'b0000, 1'b0, 1'b0);

        run_to(30);
        do_load(16'h12AF, 4'b0000);
        run_to(62);
        do_load(16'h0050, 4'b0100);
        bus.lzs = 1'b1;
        run_to(94);
        bus.lzs = 1'b0;
        run_to(126);
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        run_to(210);

        rst = 1'b1;
        step();
        chk("midrst_segments", bus.segments, 8'h00);
        chk("midrst_digit_en", {4'b0, bus.digit_en}, 8'h00);
        chk("midrst_frame_start", {7'b0, bus.frame_start}, 8'h00);
        chk("midrst_pending", {7'b0, bus.pending}, 8'h00);
        rst = 1'b0;
        cyc = 0;
        push_frame(0, 16'h0000, 4'b0000, 1'b0, 1'b0);
        push_at(33, 16'h0000, 4'b0000, 1'b0, 1'b0);
        run_to(34);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
